// File: rtl/pipelined_datapath_if.sv
// Instruction and architectural-state bundle between decode and the datapath.
interface pipelined_datapath_if #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned NREGS = 4
);
  localparam int unsigned SELW = (NREGS > 1) ? $clog2(NREGS) : 1;

  logic                   in_valid;
  logic [SELW-1:0]        sel_a;
  logic [SELW-1:0]        sel_b;
  logic [SELW-1:0]        sel_w;
  logic [WIDTH-1:0]       imm;
  logic                   sel_data;
  logic                   write_en;
  logic [1:0]             alu_op;
  logic [NREGS*WIDTH-1:0] regs_flat;
  logic                   flag_z;
  logic                   flag_c;
  logic                   flag_v;
  logic                   wb_pending;

  modport master (
    output in_valid, sel_a, sel_b, sel_w, imm, sel_data, write_en, alu_op,
    input  regs_flat, flag_z, flag_c, flag_v, wb_pending
  );

  modport slave (
    input  in_valid, sel_a, sel_b, sel_w, imm, sel_data, write_en, alu_op,
    output regs_flat, flag_z, flag_c, flag_v, wb_pending
  );
endinterface

// File: rtl/pipelined_datapath.sv
// Two-stage register file / ALU datapath (issue+execute, writeback) with operand bypass
// and a Z/C/V flag register.
module pipelined_datapath #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned NREGS = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  pipelined_datapath_if.slave  bus
);
  localparam int unsigned SELW = (NREGS > 1) ? $clog2(NREGS) : 1;
  localparam int unsigned MSB  = WIDTH - 1;

  localparam logic [1:0] OP_ADD  = 2'b00;
  localparam logic [1:0] OP_NAND = 2'b01;
  localparam logic [1:0] OP_SUB  = 2'b10;
  localparam logic [1:0] OP_MOV  = 2'b11;

  logic [WIDTH-1:0] r_regs [NREGS];
  logic [WIDTH-1:0] r_wb_data;
  logic [SELW-1:0]  r_wb_sel;
  logic             r_wb_pending;
  logic             r_flag_z;
  logic             r_flag_c;
  logic             r_flag_v;

  logic             w_in_a;
  logic             w_in_b;
  logic [WIDTH-1:0] w_a;
  logic [WIDTH-1:0] w_b;
  logic [WIDTH:0]   w_sum;
  logic [WIDTH:0]   w_dif;
  logic [WIDTH-1:0] w_res;
  logic             w_c;
  logic             w_v;
  logic             w_wb_in_range;
  logic [NREGS*WIDTH-1:0] w_flat;

  // Operand read with bypass from the writeback stage; out-of-range selects read 0.
  always_comb begin
    w_in_a = (32'(bus.sel_a) < NREGS);
    w_in_b = (32'(bus.sel_b) < NREGS);
    w_a    = '0;
    w_b    = '0;
    if (w_in_a) begin
      w_a = (r_wb_pending && (r_wb_sel == bus.sel_a)) ? r_wb_data : r_regs[bus.sel_a];
    end
    if (w_in_b) begin
      w_b = (r_wb_pending && (r_wb_sel == bus.sel_b)) ? r_wb_data : r_regs[bus.sel_b];
    end
  end

  // ALU: modulo-2^WIDTH result, carry/borrow and signed overflow.
  always_comb begin
    w_sum = {1'b0, w_a} + {1'b0, w_b};
    w_dif = {1'b0, w_a} - {1'b0, w_b};
    w_res = '0;
    w_c   = 1'b0;
    w_v   = 1'b0;
    case (bus.alu_op)
      OP_ADD: begin
        w_res = w_sum[WIDTH-1:0];
        w_c   = w_sum[WIDTH];
        w_v   = (w_a[MSB] == w_b[MSB]) && (w_res[MSB] != w_a[MSB]);
      end
      OP_NAND: w_res = ~(w_a & w_b);
      OP_SUB: begin
        w_res = w_dif[WIDTH-1:0];
        w_c   = w_dif[WIDTH];
        w_v   = (w_a[MSB] != w_b[MSB]) && (w_res[MSB] != w_a[MSB]);
      end
      OP_MOV: w_res = w_a;
      default: w_res = '0;
    endcase
  end

  assign w_wb_in_range = (32'(r_wb_sel) < NREGS);

  // Pipeline state: writeback commit, issue-stage latch and flag update.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) r_regs[i] <= '0;
      r_wb_data    <= '0;
      r_wb_sel     <= '0;
      r_wb_pending <= 1'b0;
      r_flag_z     <= 1'b0;
      r_flag_c     <= 1'b0;
      r_flag_v     <= 1'b0;
    end else begin
      if (r_wb_pending && w_wb_in_range) begin
        r_regs[r_wb_sel] <= r_wb_data;
      end
      if (bus.in_valid) begin
        r_wb_pending <= bus.write_en;
        r_wb_sel     <= bus.sel_w;
        r_wb_data    <= bus.sel_data ? bus.imm : w_res;
        if (!bus.sel_data) begin
          r_flag_z <= (w_res == '0);
          r_flag_c <= w_c;
          r_flag_v <= w_v;
        end
      end else begin
        r_wb_pending <= 1'b0;
      end
    end
  end

  // Flatten the register file for the architectural-state output.
  always_comb begin
    w_flat = '0;
    for (int i = 0; i < NREGS; i++) w_flat[i*WIDTH +: WIDTH] = r_regs[i];
  end

  assign bus.regs_flat  = w_flat;
  assign bus.flag_z     = r_flag_z;
  assign bus.flag_c     = r_flag_c;
  assign bus.flag_v     = r_flag_v;
  assign bus.wb_pending = r_wb_pending;
endmodule

// File: tb/tb_pipelined_datapath.sv
// Scoreboard bench for pipelined_datapath: a 4x4 instance and an 8x8 instance.
module tb_pipelined_datapath;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   n_tests = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  pipelined_datapath_if #(.WIDTH(4), .NREGS(4)) b4 ();
  pipelined_datapath_if #(.WIDTH(8), .NREGS(8)) b8 ();

  pipelined_datapath #(.WIDTH(4), .NREGS(4)) u_dut4 (.clk(clk), .rst(rst), .bus(b4));
  pipelined_datapath #(.WIDTH(8), .NREGS(8)) u_dut8 (.clk(clk), .rst(rst), .bus(b8));

  typedef struct { int due; int dut; logic [63:0] regs; } reg_exp_t;
  typedef struct { int due; int dut; logic z; logic c; logic v; logic wbp; } flg_exp_t;
  reg_exp_t rq[$];
  flg_exp_t fq[$];

  localparam logic [1:0] ADD = 2'b00, NAND = 2'b01, SUB = 2'b10, MOV = 2'b11;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: flags/wb_pending one edge after issue, registers two edges after issue.
  always @(negedge clk) begin
    flg_exp_t fe;
    reg_exp_t re;
    while (fq.size() > 0 && fq[0].due <= cyc) begin
      fe = fq.pop_front();
      if (fe.due < cyc) chk("flag_slot_missed", 64'(fe.due), 64'(cyc));
      else if (fe.dut == 0) begin
        chk("dut4_flag_z", 64'(b4.flag_z), 64'(fe.z));
        chk("dut4_flag_c", 64'(b4.flag_c), 64'(fe.c));
        chk("dut4_flag_v", 64'(b4.flag_v), 64'(fe.v));
        chk("dut4_wb_pending", 64'(b4.wb_pending), 64'(fe.wbp));
      end else begin
        chk("dut8_flag_z", 64'(b8.flag_z), 64'(fe.z));
        chk("dut8_flag_c", 64'(b8.flag_c), 64'(fe.c));
        chk("dut8_flag_v", 64'(b8.flag_v), 64'(fe.v));
        chk("dut8_wb_pending", 64'(b8.wb_pending), 64'(fe.wbp));
      end
    end
    while (rq.size() > 0 && rq[0].due <= cyc) begin
      re = rq.pop_front();
      if (re.due < cyc) chk("reg_slot_missed", 64'(re.due), 64'(cyc));
      else if (re.dut == 0) chk("dut4_regs_flat", 64'(b4.regs_flat), re.regs);
      else chk("dut8_regs_flat", b8.regs_flat, re.regs);
    end
  end

  // Drive one cycle of input on the chosen DUT and queue its expected results.
  task automatic issue(input int d, input logic v, input logic sd, input logic we,
                       input logic [1:0] op, input int sa, input int sb, input int sw,
                       input logic [7:0] im, input logic [63:0] eregs,
                       input logic ez, input logic ec, input logic ev);
    flg_exp_t fe;
    reg_exp_t re;
    @(negedge clk);
    if (d == 0) begin
      b4.in_valid = v;  b4.sel_data = sd; b4.write_en = we; b4.alu_op = op;
      b4.sel_a = 2'(sa); b4.sel_b = 2'(sb); b4.sel_w = 2'(sw); b4.imm = 4'(im);
    end else begin
      b8.in_valid = v;  b8.sel_data = sd; b8.write_en = we; b8.alu_op = op;
      b8.sel_a = 3'(sa); b8.sel_b = 3'(sb); b8.sel_w = 3'(sw); b8.imm = im;
    end
    fe.due = cyc + 1; fe.dut = d; fe.z = ez; fe.c = ec; fe.v = ev; fe.wbp = v & we;
    re.due = cyc + 2; re.dut = d; re.regs = eregs;
    fq.push_back(fe);
    rq.push_back(re);
  endtask

  task automatic push(input int d, input int sw, input logic [7:0] im,
                      input logic [63:0] eregs, input logic ez, input logic ec, input logic ev);
    issue(d, 1'b1, 1'b1, 1'b1, ADD, 0, 0, sw, im, eregs, ez, ec, ev);
  endtask

  task automatic alu(input int d, input logic [1:0] op, input int sw, input int sa, input int sb,
                     input logic we, input logic [63:0] eregs,
                     input logic ez, input logic ec, input logic ev);
    issue(d, 1'b1, 1'b0, we, op, sa, sb, sw, 8'h00, eregs, ez, ec, ev);
  endtask

  task automatic idle();
    @(negedge clk);
    b4.in_valid = 1'b0;
    b8.in_valid = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 20 && (rq.size() > 0 || fq.size() > 0); i++) @(negedge clk);
    if (rq.size() > 0 || fq.size() > 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL drain: %0d entries left, required 0", rq.size() + fq.size());
      rq.delete();
      fq.delete();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    b4.in_valid = 0; b4.sel_data = 0; b4.write_en = 0; b4.alu_op = 0;
    b4.sel_a = 0; b4.sel_b = 0; b4.sel_w = 0; b4.imm = 0;
    b8.in_valid = 0; b8.sel_data = 0; b8.write_en = 0; b8.alu_op = 0;
    b8.sel_a = 0; b8.sel_b = 0; b8.sel_w = 0; b8.imm = 0;
    repeat (2) @(negedge clk);
    chk("reset_regs4", 64'(b4.regs_flat), 64'h0);
    chk("reset_flags4", 64'({b4.flag_z, b4.flag_c, b4.flag_v}), 64'h0);
    chk("reset_wbp4", 64'(b4.wb_pending), 64'h0);
    chk("reset_regs8", b8.regs_flat, 64'h0);
    rst = 1'b0;

    // Immediate loads; flags stay 0.
    push(0, 0, 8'h0, 64'h0000, 0, 0, 0);
    push(0, 1, 8'hF, 64'h00F0, 0, 0, 0);
    push(0, 2, 8'h2, 64'h02F0, 0, 0, 0);
    push(0, 3, 8'hD, 64'hD2F0, 0, 0, 0);
    // Back-to-back dependent ADDs through the bypass.
    alu(0, ADD, 2, 1, 0, 1'b1, 64'hDFF0, 0, 0, 0);
    alu(0, ADD, 3, 2, 1, 1'b1, 64'hEFF0, 0, 1, 0);
    // NAND, compare, SUB with borrow, ADD overflow, MOV.
    push(0, 1, 8'hE, 64'hEFE0, 0, 1, 0);
    push(0, 3, 8'hC, 64'hCFE0, 0, 1, 0);
    alu(0, NAND, 2, 1, 3, 1'b1, 64'hC3E0, 0, 0, 0);
    alu(0, SUB, 0, 1, 1, 1'b0, 64'hC3E0, 1, 0, 0);
    push(0, 0, 8'h2, 64'hC3E2, 1, 0, 0);
    alu(0, SUB, 1, 0, 2, 1'b1, 64'hC3F2, 0, 1, 0);
    push(0, 0, 8'h7, 64'hC3F7, 0, 1, 0);
    push(0, 1, 8'h1, 64'hC317, 0, 1, 0);
    alu(0, ADD, 3, 0, 1, 1'b1, 64'h8317, 0, 0, 1);
    alu(0, MOV, 2, 0, 3, 1'b1, 64'h8717, 0, 0, 0);
    // Bubbles with random fields, then write_en=0 ALU and immediate.
    for (int i = 0; i < 2; i++)
      issue(0, 1'b0, 1'($urandom_range(0, 1)), 1'b1, 2'($urandom_range(0, 3)),
            int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
            8'($urandom_range(0, 15)), 64'h8717, 0, 0, 0);
    alu(0, ADD, 0, 0, 0, 1'b0, 64'h8717, 0, 0, 1);
    issue(0, 1'b1, 1'b1, 1'b0, ADD, 0, 0, 0, 8'h5, 64'h8717, 0, 0, 1);
    idle();
    drain();

    // Reset between the issue and writeback edges of push r0=1010.
    @(negedge clk);
    b4.in_valid = 1; b4.sel_data = 1; b4.write_en = 1; b4.sel_w = 2'd0; b4.imm = 4'hA;
    @(posedge clk);
    #1;
    chk("midrst_wbp_before", 64'(b4.wb_pending), 64'h1);
    b4.in_valid = 0;
    rst = 1'b1;
    #1;
    chk("midrst_regs", 64'(b4.regs_flat), 64'h0);
    chk("midrst_wbp", 64'(b4.wb_pending), 64'h0);
    chk("midrst_flags", 64'({b4.flag_z, b4.flag_c, b4.flag_v}), 64'h0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_r0_never_written", 64'(b4.regs_flat), 64'h0);
    push(0, 1, 8'h3, 64'h0030, 0, 0, 0);
    idle();
    drain();

    // Parametric instance, WIDTH=8, NREGS=8.
    push(1, 7, 8'hFF, 64'hFF00_0000_0000_0000, 0, 0, 0);
    push(1, 6, 8'h01, 64'hFF01_0000_0000_0000, 0, 0, 0);
    alu(1, ADD, 5, 7, 6, 1'b1, 64'hFF01_0000_0000_0000, 1, 1, 0);
    alu(1, SUB, 4, 6, 7, 1'b1, 64'hFF01_0002_0000_0000, 0, 1, 0);
    idle();
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
